// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - decode-side hazard inputs and pipeline register controls
interface pipeline_hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       branch_taken;
  logic       mem_busy;
  logic       pc_ld;
  logic       if_id_ld;
  logic       if_id_flush;
  logic       id_ex_ld;
  logic       id_ex_bubble;
  logic       ex_mem_ld;
  logic       mem_wb_ld;

  // Pipeline side: reports the ID/EX status, consumes the register controls.
  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_mem_read, branch_taken, mem_busy,
    input  pc_ld, if_id_ld, if_id_flush, id_ex_ld, id_ex_bubble, ex_mem_ld, mem_wb_ld
  );

  // Controller side.
  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_mem_read, branch_taken, mem_busy,
    output pc_ld, if_id_ld, if_id_flush, id_ex_ld, id_ex_bubble, ex_mem_ld, mem_wb_ld
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use, branch flush and memory freeze control for a 5-stage pipeline
module pipeline_hazard_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  pipeline_hazard_ctrl_if.slave hz,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   flush_cnt_o,
  output logic               mem_timeout_o
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic {RUN, MEM_WAIT} state_e;

  state_e              state_q, state_d;
  logic                flush_pend_q, flush_pend_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic                mem_timeout_q, mem_timeout_d;

  logic hazard;
  logic flush_now;
  logic pc_ld, if_id_ld, if_id_flush, id_ex_ld, id_ex_bubble, ex_mem_ld, mem_wb_ld;

  // Register controls: freeze beats flush beats load-use; everything held low in reset.
  always_comb begin
    hazard = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
             ((hz.id_uses_rs && (hz.ex_rd == hz.id_rs)) ||
              (hz.id_uses_rt && (hz.ex_rd == hz.id_rt)));
    flush_now    = !hz.mem_busy && (hz.branch_taken || flush_pend_q);
    pc_ld        = 1'b0;
    if_id_ld     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_ld     = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_ld    = 1'b0;
    mem_wb_ld    = 1'b0;
    if (!rst_i && !hz.mem_busy) begin
      id_ex_ld  = 1'b1;
      ex_mem_ld = 1'b1;
      mem_wb_ld = 1'b1;
      if (flush_now) begin
        // The wrong-path instruction in ID is discarded, so a hazard on it is moot.
        pc_ld        = 1'b1;
        if_id_ld     = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (hazard) begin
        // Hold PC and IF/ID one cycle; the nop sent to EX clears the hazard.
        id_ex_bubble = 1'b1;
      end else begin
        pc_ld    = 1'b1;
        if_id_ld = 1'b1;
      end
    end
    hz.pc_ld        = pc_ld;
    hz.if_id_ld     = if_id_ld;
    hz.if_id_flush  = if_id_flush;
    hz.id_ex_ld     = id_ex_ld;
    hz.id_ex_bubble = id_ex_bubble;
    hz.ex_mem_ld    = ex_mem_ld;
    hz.mem_wb_ld    = mem_wb_ld;
  end

  // Next state: freeze tracking, deferred flush, wait watchdog and saturating counters.
  always_comb begin
    state_d       = hz.mem_busy ? MEM_WAIT : RUN;
    flush_pend_d  = flush_pend_q;
    wait_cnt_d    = '0;
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    if (hz.mem_busy && hz.branch_taken) begin
      flush_pend_d = 1'b1;
    end else if (flush_now) begin
      flush_pend_d = 1'b0;
    end
    if ((state_q == MEM_WAIT) && hz.mem_busy) begin
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
    end
    mem_timeout_d = mem_timeout_q || (wait_cnt_d == WAIT_MAX);
    if (!pc_ld && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_now && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= RUN;
      flush_pend_q  <= 1'b0;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_pend_q  <= flush_pend_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;
  assign mem_timeout_o = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scenario and randomized checks of pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W    = 16;
  localparam int MAX_WAIT = 64;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
  localparam logic [6:0] V_ZERO   = 7'b0000000;
  localparam logic [6:0] V_NORMAL = 7'b1101011;
  localparam logic [6:0] V_FLUSH  = 7'b1111111;
  localparam logic [6:0] V_LDUSE  = 7'b0001111;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  pipeline_hazard_ctrl_if hz();
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             mem_timeout;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk), .rst_i(rst), .hz(hz),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .mem_timeout_o(mem_timeout)
  );

  // {pc_ld, if_id_ld, if_id_flush, id_ex_ld, id_ex_bubble, ex_mem_ld, mem_wb_ld}
  logic [6:0] dut_vec;
  assign dut_vec = {hz.pc_ld, hz.if_id_ld, hz.if_id_flush, hz.id_ex_ld,
                    hz.id_ex_bubble, hz.ex_mem_ld, hz.mem_wb_ld};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending flush, length of current busy run, counters.
  bit m_pend;
  int m_run;
  int m_stall;
  int m_flush;
  bit m_timeout;

  function automatic logic [6:0] ref_vec();
    bit use_hz;
    use_hz = hz.ex_mem_read && (hz.ex_rd != 0) &&
             ((hz.id_uses_rs && hz.ex_rd == hz.id_rs) || (hz.id_uses_rt && hz.ex_rd == hz.id_rt));
    if (rst) return V_ZERO;
    if (hz.mem_busy) return V_ZERO;
    if (hz.branch_taken || m_pend) return V_FLUSH;
    if (use_hz) return V_LDUSE;
    return V_NORMAL;
  endfunction

  task automatic set_in(input int rs, input int rt, input bit urs, input bit urt,
                        input int rd, input bit mrd, input bit br, input bit busy);
    hz.id_rs = 5'(rs); hz.id_rt = 5'(rt); hz.id_uses_rs = urs; hz.id_uses_rt = urt;
    hz.ex_rd = 5'(rd); hz.ex_mem_read = mrd; hz.branch_taken = br; hz.mem_busy = busy;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance the model by one cycle with the current inputs, then cross the clock edge.
  task automatic tick();
    logic [6:0] ev;
    ev = ref_vec();
    if (rst) begin
      m_pend = 0; m_run = 0; m_stall = 0; m_flush = 0; m_timeout = 0;
    end else begin
      if (!ev[6] && m_stall < CNT_MAX) m_stall++;
      if (ev == V_FLUSH && m_flush < CNT_MAX) m_flush++;
      if (hz.mem_busy && hz.branch_taken) m_pend = 1;
      else if (ev == V_FLUSH) m_pend = 0;
      m_run = hz.mem_busy ? m_run + 1 : 0;
      if (m_run >= MAX_WAIT + 1) m_timeout = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== V_ZERO) begin n_fail++; $display("FAIL reset_outputs: got %b expected %b", dut_vec, V_ZERO); end
      tick();
    end
    n_checks++;
    if (stall_cnt !== '0 || flush_cnt !== '0) begin n_fail++; $display("FAIL reset_counters: got stall=%0d flush=%0d expected 0 0", stall_cnt, flush_cnt); end
    n_checks++;
    if (mem_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", mem_timeout); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dut_vec !== V_NORMAL) begin n_fail++; $display("FAIL release_outputs: got %b expected %b", dut_vec, V_NORMAL); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(5, 9, 1, 0, 5, 1, 0, 0);
    @(negedge clk);
    n_checks++;
    if (dut_vec !== V_LDUSE) begin n_fail++; $display("FAIL load_use_outputs: got %b expected %b", dut_vec, V_LDUSE); end
    tick();
    set_in(5, 9, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (dut_vec !== V_NORMAL) begin n_fail++; $display("FAIL load_use_release: got %b expected %b", dut_vec, V_NORMAL); end
    n_checks++;
    if (stall_cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL load_use_stall_cnt: got %0d expected 1", stall_cnt); end
    tick();
    // Same hazard via rt only.
    set_in(1, 7, 0, 1, 7, 1, 0, 0);
    @(negedge clk);
    n_checks++;
    if (dut_vec !== V_LDUSE) begin n_fail++; $display("FAIL load_use_rt: got %b expected %b", dut_vec, V_LDUSE); end
    tick();
    idle();
  endtask

  task automatic test_rd_zero();
    do_reset();
    set_in(0, 0, 1, 1, 0, 1, 0, 0);
    @(negedge clk);
    n_checks++;
    if (dut_vec !== V_NORMAL) begin n_fail++; $display("FAIL rd_zero_outputs: got %b expected %b", dut_vec, V_NORMAL); end
    tick();
    // Register matches but the instruction does not read it.
    set_in(6, 6, 0, 0, 6, 1, 0, 0);
    @(negedge clk);
    n_checks++;
    if (dut_vec !== V_NORMAL) begin n_fail++; $display("FAIL unused_src_outputs: got %b expected %b", dut_vec, V_NORMAL); end
    tick();
    n_checks++;
    if (stall_cnt !== '0) begin n_fail++; $display("FAIL rd_zero_stall_cnt: got %0d expected 0", stall_cnt); end
    idle();
  endtask

  task automatic test_branch_over_hazard();
    do_reset();
    set_in(5, 0, 1, 0, 5, 1, 1, 0);
    @(negedge clk);
    n_checks++;
    if (dut_vec !== V_FLUSH) begin n_fail++; $display("FAIL branch_hazard_outputs: got %b expected %b", dut_vec, V_FLUSH); end
    tick();
    idle();
    n_checks++;
    if (flush_cnt !== CNT_W'(1) || stall_cnt !== '0) begin n_fail++; $display("FAIL branch_hazard_counters: got flush=%0d stall=%0d expected 1 0", flush_cnt, stall_cnt); end
  endtask

  task automatic test_freeze_deferred_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, (i == 1), 1);
      @(negedge clk);
      n_checks++;
      if (dut_vec !== V_ZERO) begin n_fail++; $display("FAIL freeze_outputs[%0d]: got %b expected %b", i, dut_vec, V_ZERO); end
      tick();
    end
    idle();
    @(negedge clk);
    n_checks++;
    if (dut_vec !== V_FLUSH) begin n_fail++; $display("FAIL deferred_flush: got %b expected %b", dut_vec, V_FLUSH); end
    tick();
    n_checks++;
    if (stall_cnt !== CNT_W'(3) || flush_cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL freeze_counters: got stall=%0d flush=%0d expected 3 1", stall_cnt, flush_cnt); end
    @(negedge clk);
    n_checks++;
    if (dut_vec !== V_NORMAL) begin n_fail++; $display("FAIL after_deferred_flush: got %b expected %b", dut_vec, V_NORMAL); end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < MAX_WAIT - 1; i++) tick();
    n_checks++;
    if (mem_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b expected 0", mem_timeout); end
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (mem_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_set: got %b expected 1", mem_timeout); end
    n_checks++;
    if (stall_cnt !== CNT_W'(MAX_WAIT + 2)) begin n_fail++; $display("FAIL timeout_stall_cnt: got %0d expected %0d", stall_cnt, MAX_WAIT + 2); end
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== V_NORMAL || mem_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_held[%0d]: got vec=%b to=%b expected %b 1", i, dut_vec, mem_timeout, V_NORMAL); end
      tick();
    end
    do_reset();
    n_checks++;
    if (mem_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_cleared: got %b expected 0", mem_timeout); end
  endtask

  task automatic test_random();
    logic [6:0] ev;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 1), ($urandom_range(0, 99) < 15),
             ($urandom_range(0, 99) < 25));
      @(negedge clk);
      ev = ref_vec();
      n_checks++;
      if (dut_vec !== ev) begin n_fail++; $display("FAIL random_outputs[%0d]: got %b expected %b", i, dut_vec, ev); end
      tick();
      n_checks++;
      if (stall_cnt !== CNT_W'(m_stall) || flush_cnt !== CNT_W'(m_flush) || mem_timeout !== m_timeout) begin
        n_fail++;
        $display("FAIL random_counters[%0d]: got stall=%0d flush=%0d to=%b expected %0d %0d %b",
                 i, stall_cnt, flush_cnt, mem_timeout, m_stall, m_flush, m_timeout);
      end
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    m_pend = 0; m_run = 0; m_stall = 0; m_flush = 0; m_timeout = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_rd_zero();
    test_branch_over_hazard();
    test_freeze_deferred_flush();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
